// File: rtl/komandara_elastic_buffer.sv
// Multi-entry valid/ready elastic buffer built on a circular array, with optional
// zero-latency fall-through when empty and a synchronous flush.
module komandara_elastic_buffer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic empty, full, push, pop, bypass, push_store, pop_store;

  logic                  chk_hold_q, chk_hold_d;
  logic [DATA_WIDTH-1:0] chk_data_q, chk_data_d;

  // Ready is derived from registered occupancy only, so a pop from full cannot open it this cycle.
  always_comb begin
    full      = (count_q == DEPTH_C);
    empty     = (count_q == '0);
    s_ready_o = !full && !flush_i;
    if (FALL_THROUGH && empty) begin
      m_valid_o = s_valid_i && !flush_i;
      m_data_o  = s_data_i;
    end else begin
      m_valid_o = !empty && !flush_i;
      m_data_o  = mem_q[rd_ptr_q];
    end
    push       = s_valid_i && s_ready_o;
    pop        = m_valid_o && m_ready_i;
    bypass     = FALL_THROUGH && empty && pop;
    push_store = push && !bypass;
    pop_store  = pop && !bypass;
    chk_hold_d = m_valid_o && !m_ready_i && !flush_i;
    chk_data_d = m_data_o;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_store) begin
        mem_d[wr_ptr_q] = s_data_i;
        wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_store) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_store, pop_store})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      chk_hold_q <= 1'b0;
      chk_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      chk_hold_q <= chk_hold_d;
      chk_data_q <= chk_data_d;
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (chk_hold_q && !flush_i) begin
        a_stable: assert (m_valid_o && (m_data_o == chk_data_q));
      end
      a_count_max: assert (count_q <= DEPTH_C);
      a_no_push_full: assert (!(push && full));
    end
  end

endmodule

// File: tb/tb_komandara_elastic_buffer.sv
// Directed bench for the elastic buffer: three instances (DEPTH 4 fall-through,
// DEPTH 2 registered, DEPTH 3 fall-through) share one stimulus stream.
module tb_komandara_elastic_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] s_data;
  logic       s_valid;
  logic       m_ready;

  logic       s_ready_a, m_valid_a;
  logic [7:0] m_data_a;
  logic [2:0] count_a;
  logic       s_ready_b, m_valid_b;
  logic [7:0] m_data_b;
  logic [1:0] count_b;
  logic       s_ready_c, m_valid_c;
  logic [7:0] m_data_c;
  logic [1:0] count_c;

  int n_cmp = 0;
  int n_err = 0;

  komandara_elastic_buffer #(.DATA_WIDTH(8), .DEPTH(4), .FALL_THROUGH(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_a),
    .m_data_o(m_data_a), .m_valid_o(m_valid_a), .m_ready_i(m_ready),
    .count_o(count_a)
  );

  komandara_elastic_buffer #(.DATA_WIDTH(8), .DEPTH(2), .FALL_THROUGH(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_b),
    .m_data_o(m_data_b), .m_valid_o(m_valid_b), .m_ready_i(m_ready),
    .count_o(count_b)
  );

  komandara_elastic_buffer #(.DATA_WIDTH(8), .DEPTH(3), .FALL_THROUGH(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_c),
    .m_data_o(m_data_c), .m_valid_o(m_valid_c), .m_ready_i(m_ready),
    .count_o(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 8'h3C; m_ready = 1'b0;
    #1;
    n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("[TB] FAIL reset_s_ready_a: got %0b expected 1", s_ready_a); end
    n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("[TB] FAIL reset_count_a: got %0d expected 0", count_a); end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL reset_m_valid_a_idle: got %0b expected 0", m_valid_a); end
    s_valid = 1'b1;
    #1;
    n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("[TB] FAIL reset_m_valid_a_ft: got %0b expected 1", m_valid_a); end
    n_cmp++; if (m_valid_b !== 1'b0) begin n_err++; $display("[TB] FAIL reset_m_valid_b_reg: got %0b expected 0", m_valid_b); end
    n_cmp++; if (s_ready_b !== 1'b1) begin n_err++; $display("[TB] FAIL reset_s_ready_b: got %0b expected 1", s_ready_b); end
    n_cmp++; if (count_b !== 2'd0) begin n_err++; $display("[TB] FAIL reset_count_b: got %0d expected 0", count_b); end
    s_valid = 1'b0;
  endtask

  task automatic test_pass_through();
    do_reset();
    @(negedge clk);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    #1;
    n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("[TB] FAIL pt_m_valid: got %0b expected 1", m_valid_a); end
    n_cmp++; if (m_data_a !== 8'hA5) begin n_err++; $display("[TB] FAIL pt_m_data: got %0h expected a5", m_data_a); end
    n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("[TB] FAIL pt_count_same: got %0d expected 0", count_a); end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("[TB] FAIL pt_count_after: got %0d expected 0", count_a); end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL pt_m_valid_after: got %0b expected 0", m_valid_a); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'(i); m_ready = 1'b0;
      #1;
      n_cmp++; if (s_ready_a !== (i <= 4)) begin n_err++; $display("[TB] FAIL fill_s_ready[%0d]: got %0b expected %0b", i, s_ready_a, (i <= 4)); end
      n_cmp++; if (count_a !== 3'((i - 1 > 4) ? 4 : i - 1)) begin n_err++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, count_a, (i - 1 > 4) ? 4 : i - 1); end
      n_cmp++; if (m_data_a !== 8'h01) begin n_err++; $display("[TB] FAIL fill_head[%0d]: got %0h expected 01", i, m_data_a); end
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b1;
      #1;
      n_cmp++; if (m_valid_a !== (k <= 4)) begin n_err++; $display("[TB] FAIL drain_m_valid[%0d]: got %0b expected %0b", k, m_valid_a, (k <= 4)); end
      if (k <= 4) begin
        n_cmp++; if (m_data_a !== 8'(k)) begin n_err++; $display("[TB] FAIL drain_m_data[%0d]: got %0h expected %0h", k, m_data_a, k); end
      end
      n_cmp++; if (count_a !== 3'(5 - ((k > 4) ? 5 : k))) begin n_err++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", k, count_a, 5 - ((k > 4) ? 5 : k)); end
      n_cmp++; if (s_ready_a !== (k > 1)) begin n_err++; $display("[TB] FAIL drain_s_ready[%0d]: got %0b expected %0b", k, s_ready_a, (k > 1)); end
    end
  endtask

  task automatic test_registered();
    logic exp_v;
    do_reset();
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = (j <= 2);
      s_data  = 8'(8'h10 + j);
      #1;
      exp_v = (j >= 1) && (j <= 3);
      n_cmp++; if (m_valid_b !== exp_v) begin n_err++; $display("[TB] FAIL reg_m_valid[%0d]: got %0b expected %0b", j, m_valid_b, exp_v); end
      if (exp_v) begin
        n_cmp++; if (m_data_b !== 8'(8'h10 + j - 1)) begin n_err++; $display("[TB] FAIL reg_m_data[%0d]: got %0h expected %0h", j, m_data_b, 8'h10 + j - 1); end
      end
      n_cmp++; if (count_b !== {1'b0, exp_v}) begin n_err++; $display("[TB] FAIL reg_count[%0d]: got %0d expected %0d", j, count_b, exp_v); end
      n_cmp++; if (s_ready_b !== 1'b1) begin n_err++; $display("[TB] FAIL reg_s_ready[%0d]: got %0b expected 1", j, s_ready_b); end
    end
  endtask

  task automatic test_wrap_random();
    logic [7:0] q[$];
    logic [7:0] next_in;
    logic       exp_v, push, pop;
    do_reset();
    next_in = 8'h00;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = next_in;
      #1;
      n_cmp++; if (count_c !== 2'(q.size())) begin n_err++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", n, count_c, q.size()); end
      n_cmp++; if (s_ready_c !== (q.size() != 3)) begin n_err++; $display("[TB] FAIL rnd_s_ready[%0d]: got %0b expected %0b", n, s_ready_c, (q.size() != 3)); end
      exp_v = (q.size() > 0) || s_valid;
      n_cmp++; if (m_valid_c !== exp_v) begin n_err++; $display("[TB] FAIL rnd_m_valid[%0d]: got %0b expected %0b", n, m_valid_c, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (m_data_c !== ((q.size() > 0) ? q[0] : s_data)) begin
          n_err++; $display("[TB] FAIL rnd_m_data[%0d]: got %0h expected %0h", n, m_data_c, (q.size() > 0) ? q[0] : s_data);
        end
      end
      push = s_valid && (q.size() != 3);
      pop  = exp_v && m_ready;
      if (push) begin q.push_back(s_data); next_in = next_in + 8'h01; end
      if (pop) void'(q.pop_front());
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'(i); m_ready = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h55; flush = 1'b1;
    #1;
    n_cmp++; if (count_a !== 3'd3) begin n_err++; $display("[TB] FAIL flush_count_before: got %0d expected 3", count_a); end
    n_cmp++; if (s_ready_a !== 1'b0) begin n_err++; $display("[TB] FAIL flush_s_ready: got %0b expected 0", s_ready_a); end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL flush_m_valid: got %0b expected 0", m_valid_a); end
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    #1;
    n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("[TB] FAIL flush_count_after: got %0d expected 0", count_a); end
    n_cmp++; if (m_valid_a !== 1'b1) begin n_err++; $display("[TB] FAIL flush_next_valid: got %0b expected 1", m_valid_a); end
    n_cmp++; if (m_data_a !== 8'h77) begin n_err++; $display("[TB] FAIL flush_next_data: got %0h expected 77", m_data_a); end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("[TB] FAIL flush_held_count: got %0d expected 1", count_a); end
    n_cmp++; if (m_data_a !== 8'h77) begin n_err++; $display("[TB] FAIL flush_held_data: got %0h expected 77", m_data_a); end
    @(negedge clk);
    #1;
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL flush_empty_after: got %0b expected 0", m_valid_a); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'(8'h31 + i); m_ready = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_cmp++; if (count_a !== 3'd2) begin n_err++; $display("[TB] FAIL arst_count_before: got %0d expected 2", count_a); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("[TB] FAIL arst_count_now: got %0d expected 0", count_a); end
    n_cmp++; if (s_ready_a !== 1'b1) begin n_err++; $display("[TB] FAIL arst_s_ready_now: got %0b expected 1", s_ready_a); end
    n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL arst_m_valid_now: got %0b expected 0", m_valid_a); end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      n_cmp++; if (m_valid_a !== 1'b0) begin n_err++; $display("[TB] FAIL arst_stale[%0d]: got %0b expected 0", k, m_valid_a); end
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h44;
    #1;
    n_cmp++; if (m_data_a !== 8'h44) begin n_err++; $display("[TB] FAIL arst_next_data: got %0h expected 44", m_data_a); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_drain();
    test_registered();
    test_wrap_random();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
